// File: rtl/adc_pkg.sv
// Shared constants, control-word bit positions and FSM encoding for the ADC SPI responder.
package adc_pkg;

   localparam int FRAME_LEN = 16;
   localparam int HDR_W     = 4;
   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 3;
   localparam int CNT_W     = 5;

   // Control-word bit positions; multi-bit fields are given as HI/LO pairs.
   typedef enum int unsigned {
      CTRL_CODING = 4,
      CTRL_RANGE  = 5,
      CTRL_SHADOW = 7,
      CTRL_PM_LO  = 8,
      CTRL_PM_HI  = 9,
      CTRL_ADD_LO = 10,
      CTRL_ADD_HI = 12,
      CTRL_SEQ    = 14,
      CTRL_WRITE  = 15
   } ctrl_bit_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Out-frame layout: leading zero, echoed address, sample byte, zero tail.
   function automatic logic [FRAME_LEN-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                        input logic [DATA_W-1:0] data);
      return {1'b0, addr, data, {(FRAME_LEN-HDR_W-DATA_W){1'b0}}};
   endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI bus between an ADC initiator (master) and the emulated ADC (slave).
interface adc_spi_responder_if;
   logic adc_cs_n;
   logic adc_sclk;
   logic adc_din;
   logic adc_data_in;

   modport master (output adc_cs_n, output adc_sclk, output adc_din, input adc_data_in);
   modport slave  (input adc_cs_n, input adc_sclk, input adc_din, output adc_data_in);
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle rise/fall pulses.
module sync_edge_det #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;
   logic [STAGES:0]   prime_q, prime_d;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      sync_d  = STAGES'({sync_q, async_in});
      prev_d  = sync_q[STAGES-1];
      prime_d = {prime_q[STAGES-1:0], 1'b1};
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so every flop
   // samples the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= {STAGES{RST_VAL}};
         prev_q  <= RST_VAL;
         prime_q <= '0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         prime_q <= prime_d;
      end
   end

   // Edges are masked until the chain has refilled after reset, so a line already
   // away from its idle level at release does not look like a fresh edge.
   assign sync_out = sync_q[STAGES-1];
   assign rise     = prime_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
   assign fall     = prime_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// Emulated SPI ADC: returns a channel sample per 16-bit frame and captures the control word,
// with the one-frame address pipeline of the real converter.
module adc_spi_responder
   import adc_pkg::*;
#(
   parameter int CH_COUNT    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   adc_spi_responder_if.slave         spi,
   input  logic [DATA_W*CH_COUNT-1:0] ch_values,
   output logic [FRAME_LEN-1:0]       ctrl_word,
   output logic                       frame_done,
   output logic                       frame_abort
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);

   logic cs_sync_unused, cs_rise, cs_fall;
   logic sclk_sync_unused, sclk_rise, sclk_fall;
   logic din_sync, din_rise_unused, din_fall_unused;

   sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .async_in(spi.adc_cs_n),
      .sync_out(cs_sync_unused), .rise(cs_rise), .fall(cs_fall)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .rst(rst), .async_in(spi.adc_sclk),
      .sync_out(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din_sync (
      .clk(clk), .rst(rst), .async_in(spi.adc_din),
      .sync_out(din_sync), .rise(din_rise_unused), .fall(din_fall_unused)
   );

   state_e               state_q, state_d;
   logic [FRAME_LEN-1:0] out_q, out_d;
   logic [FRAME_LEN-1:0] ctrl_sr_q, ctrl_sr_d;
   logic [CNT_W-1:0]     rise_cnt_q, rise_cnt_d;
   logic [FRAME_LEN-1:0] ctrl_word_q, ctrl_word_d;
   logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d;
   logic [ADDR_W-1:0]    next_addr_q, next_addr_d;
   logic                 adc_data_in_q, adc_data_in_d;
   logic                 frame_done_q, frame_done_d;
   logic                 frame_abort_q, frame_abort_d;

   logic [DATA_W-1:0]    ch_byte;
   logic [FRAME_LEN-1:0] load_frame;

   // Addresses without a backing channel read as zero data.
   always_comb begin
      ch_byte = '0;
      for (int n = 0; n < CH_COUNT; n++) begin
         if (cur_addr_q == ADDR_W'(n)) ch_byte = ch_values[DATA_W*n +: DATA_W];
      end
      load_frame = build_frame(cur_addr_q, ch_byte);
   end

   always_comb begin
      state_d       = state_q;
      out_d         = out_q;
      ctrl_sr_d     = ctrl_sr_q;
      rise_cnt_d    = rise_cnt_q;
      ctrl_word_d   = ctrl_word_q;
      cur_addr_d    = cur_addr_q;
      next_addr_d   = next_addr_q;
      adc_data_in_d = adc_data_in_q;
      frame_done_d  = 1'b0;
      frame_abort_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            adc_data_in_d = 1'b0;
            if (cs_fall) begin
               out_d         = load_frame;
               adc_data_in_d = load_frame[FRAME_LEN-1];
               ctrl_sr_d     = '0;
               rise_cnt_d    = '0;
               state_d       = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (cs_rise) begin
               adc_data_in_d = 1'b0;
               if (rise_cnt_q == FULL_CNT) begin
                  state_d = ST_DONE;
               end else begin
                  frame_abort_d = 1'b1;
                  state_d       = ST_IDLE;
               end
            end else begin
               if (sclk_rise && rise_cnt_q != FULL_CNT) begin
                  ctrl_sr_d  = {ctrl_sr_q[FRAME_LEN-2:0], din_sync};
                  rise_cnt_d = rise_cnt_q + 1'b1;
               end
               // The falling edge after rise k presents frame bit 15-k to the initiator.
               if (sclk_fall) begin
                  if (rise_cnt_q == FULL_CNT) begin
                     adc_data_in_d = 1'b0;
                  end else if (rise_cnt_q != '0) begin
                     out_d         = out_q << 1;
                     adc_data_in_d = out_q[FRAME_LEN-2];
                  end
               end
            end
         end

         ST_DONE: begin
            cur_addr_d = next_addr_q;
            if (ctrl_sr_q[CTRL_WRITE]) begin
               ctrl_word_d = ctrl_sr_q;
               next_addr_d = ctrl_sr_q[CTRL_ADD_HI:CTRL_ADD_LO];
            end
            adc_data_in_d = 1'b0;
            frame_done_d  = 1'b1;
            state_d       = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         out_q         <= '0;
         ctrl_sr_q     <= '0;
         rise_cnt_q    <= '0;
         ctrl_word_q   <= '0;
         cur_addr_q    <= '0;
         next_addr_q   <= '0;
         adc_data_in_q <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_abort_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_q         <= out_d;
         ctrl_sr_q     <= ctrl_sr_d;
         rise_cnt_q    <= rise_cnt_d;
         ctrl_word_q   <= ctrl_word_d;
         cur_addr_q    <= cur_addr_d;
         next_addr_q   <= next_addr_d;
         adc_data_in_q <= adc_data_in_d;
         frame_done_q  <= frame_done_d;
         frame_abort_q <= frame_abort_d;
      end
   end

   assign spi.adc_data_in = adc_data_in_q;
   assign ctrl_word       = ctrl_word_q;
   assign frame_done      = frame_done_q;
   assign frame_abort     = frame_abort_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: a bit-banged SPI initiator issues frames, and a
// scoreboard monitor compares each frame_done/frame_abort pulse with the queued expectation.
module tb_adc_spi_responder;
   import adc_pkg::*;

   localparam int CH_COUNT  = 4;
   localparam int HALF      = 10;
   localparam int SLOW_HALF = 40;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   adc_spi_responder_if spi ();

   logic [8*CH_COUNT-1:0] ch_values;
   logic [15:0]           ctrl_word;
   logic                  frame_done;
   logic                  frame_abort;

   adc_spi_responder #(.CH_COUNT(CH_COUNT), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .spi        (spi),
      .ch_values  (ch_values),
      .ctrl_word  (ctrl_word),
      .frame_done (frame_done),
      .frame_abort(frame_abort)
   );

   typedef struct {
      bit          is_done;
      logic [15:0] frame;
      logic [15:0] ctrl;
   } exp_t;

   exp_t        sb_q[$];
   int          checks    = 0;
   int          errors    = 0;
   int          pulse_cnt = 0;
   logic [15:0] last_cap  = '0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_frame(input bit is_done, input logic [15:0] frame, input logic [15:0] ctrl);
      exp_t e;
      e.is_done = is_done;
      e.frame   = frame;
      e.ctrl    = ctrl;
      sb_q.push_back(e);
   endtask

   // Mode-0 initiator: din changes while SCLK is low, MISO is captured at each rising edge.
   task automatic spi_xfer(input logic [15:0] ctrl, input int n_rise, input int half);
      logic [15:0] cap;
      cap = '0;
      spi.adc_cs_n = 1'b0;
      wait_clk(half);
      for (int i = 0; i < n_rise; i++) begin
         spi.adc_din = (i < 16) ? ctrl[15-i] : 1'b1;
         wait_clk(half);
         spi.adc_sclk = 1'b1;
         if (i < 16) cap = {cap[14:0], spi.adc_data_in};
         wait_clk(half);
         spi.adc_sclk = 1'b0;
      end
      last_cap = cap;
      wait_clk(half);
      spi.adc_cs_n = 1'b1;
      spi.adc_din  = 1'b0;
      wait_clk(2 * half);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(5);
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (frame_done === 1'b1 || frame_abort === 1'b1) begin
            pulse_cnt++;
            if (sb_q.size() == 0) begin
               check("unexpected_pulse", {14'b0, frame_done, frame_abort}, 16'h0);
            end else begin
               e = sb_q.pop_front();
               check("pulse_kind", {14'b0, frame_done, frame_abort}, e.is_done ? 16'h2 : 16'h1);
               if (e.is_done) check("frame_out", last_cap, e.frame);
               check("ctrl_word", ctrl_word, e.ctrl);
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached with %0d pending", sb_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] cds, dial;
      logic [15:0] slow_ctrl  [4] = '{16'h8000, 16'h8400, 16'h8000, 16'h8400};
      logic [15:0] slow_frame [4] = '{16'h0120, 16'h0120, 16'h0120, 16'h1EF0};
      int saved_pulses;

      rst          = 1'b1;
      spi.adc_cs_n = 1'b1;
      spi.adc_sclk = 1'b0;
      spi.adc_din  = 1'b0;
      ch_values    = {8'h00, 8'h00, 8'h3C, 8'hA5};
      wait_clk(3);
      check("rst_miso", {15'b0, spi.adc_data_in}, 16'h0);
      check("rst_ctrl_word", ctrl_word, 16'h0000);
      check("rst_frame_done", {15'b0, frame_done}, 16'h0);
      check("rst_frame_abort", {15'b0, frame_abort}, 16'h0);
      rst = 1'b0;
      wait_clk(5);

      // Read-only frame from reset returns ch0.
      expect_frame(1, 16'h0A50, 16'h0000);
      spi_xfer(16'h0000, 16, HALF);
      check("idle_miso", {15'b0, spi.adc_data_in}, 16'h0);

      // Address pipeline: ADD=1 written in frame 1 is returned in frame 3.
      expect_frame(1, 16'h0A50, 16'h8770);
      spi_xfer(16'h8770, 16, HALF);
      expect_frame(1, 16'h0A50, 16'h8370);
      spi_xfer(16'h8370, 16, HALF);
      expect_frame(1, 16'h13C0, 16'h8370);
      spi_xfer(16'h0000, 16, HALF);

      // Abort after 7 rises, then an over-long frame (extra rises ignored).
      expect_frame(1, 16'h0A50, 16'h8770);
      spi_xfer(16'h8770, 16, HALF);
      expect_frame(0, 16'h0000, 16'h8770);
      spi_xfer(16'h8370, 7, HALF);
      expect_frame(1, 16'h0A50, 16'h8774);
      spi_xfer(16'h8774, 18, HALF);
      expect_frame(1, 16'h13C0, 16'h8774);
      spi_xfer(16'h0000, 16, HALF);

      // Slow initiator alternating ch0/ch1, decoding returns into cds/dial.
      ch_values = {8'h00, 8'h00, 8'hEF, 8'h12};
      pulse_reset();
      cds  = '0;
      dial = '0;
      for (int f = 0; f < 4; f++) begin
         expect_frame(1, slow_frame[f], slow_ctrl[f]);
         spi_xfer(slow_ctrl[f], 16, SLOW_HALF);
         if (last_cap[14:12] == 3'd0) cds = last_cap[11:4];
         else if (last_cap[14:12] == 3'd1) dial = last_cap[11:4];
      end
      check("cds_value", {8'h00, cds}, 16'h0012);
      check("dial_value", {8'h00, dial}, 16'h00EF);

      // Address 6 beyond CH_COUNT=4 echoes the address with zero data.
      expect_frame(1, 16'h0120, 16'h9800);
      spi_xfer(16'h9800, 16, HALF);
      expect_frame(1, 16'h1EF0, 16'h9800);
      spi_xfer(16'h0000, 16, HALF);
      expect_frame(1, 16'h6000, 16'h9800);
      spi_xfer(16'h0000, 16, HALF);

      // Reset during bit 9 of a ch1 frame.
      ch_values = {8'h00, 8'h00, 8'h3C, 8'hA5};
      pulse_reset();
      expect_frame(1, 16'h0A50, 16'h8400);
      spi_xfer(16'h8400, 16, HALF);
      expect_frame(1, 16'h0A50, 16'h8400);
      spi_xfer(16'h0000, 16, HALF);
      spi.adc_cs_n = 1'b0;
      wait_clk(HALF);
      for (int i = 0; i < 6; i++) begin
         wait_clk(HALF);
         spi.adc_sclk = 1'b1;
         wait_clk(HALF);
         spi.adc_sclk = 1'b0;
      end
      wait_clk(HALF);
      check("bit9_before_rst", {15'b0, spi.adc_data_in}, 16'h1);
      saved_pulses = pulse_cnt;
      rst = 1'b1;
      #1;
      check("miso_at_rst", {15'b0, spi.adc_data_in}, 16'h0);
      wait_clk(3);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wait_clk(HALF);
         spi.adc_sclk = 1'b1;
         wait_clk(HALF);
         spi.adc_sclk = 1'b0;
      end
      wait_clk(HALF);
      spi.adc_cs_n = 1'b1;
      wait_clk(2 * HALF);
      check("no_pulse_after_rst", 16'(pulse_cnt), 16'(saved_pulses));
      expect_frame(1, 16'h0A50, 16'h0000);
      spi_xfer(16'h0000, 16, HALF);

      wait_clk(20);
      check("scoreboard_drained", 16'(sb_q.size()), 16'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
